// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : First-word-fall-through receive byte buffer with sticky overrun flag.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              ovf_clr
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Extra pointer MSB distinguishes a full buffer from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign w_pop  = !w_empty && rd_ready;
    assign w_push = wr_en && (!w_full || w_pop);
    assign w_drop = wr_en && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign rd_valid = !w_empty;
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_wr_ptr - r_rd_ptr;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
